// File: rtl/ssd1309_pkg.sv
// Shared opcodes, addressing-mode codes and parser state encoding for the SSD1309 SPI receiver.
// Page-mode opcodes (0xB0-0xB7, 0x00-0x17) are decoded only when SSD_RX_PAGE_MODE_EN is defined.
package ssd1309_pkg;

  typedef enum logic [1:0] {
    P_CMD  = 2'd0,
    P_ARG1 = 2'd1,
    P_ARG2 = 2'd2
  } parser_state_t;

  localparam logic [1:0] ADDR_HORIZ = 2'd0;
  localparam logic [1:0] ADDR_VERT  = 2'd1;
  localparam logic [1:0] ADDR_PAGE  = 2'd2;

  localparam logic [7:0] CMD_MEM_MODE  = 8'h20;
  localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;
  localparam logic [7:0] CMD_CONTRAST  = 8'h81;
  localparam logic [7:0] CMD_MUX_RATIO = 8'hA8;
  localparam logic [7:0] CMD_OFFSET    = 8'hD3;
  localparam logic [7:0] CMD_CLK_DIV   = 8'hD5;
  localparam logic [7:0] CMD_PRECHARGE = 8'hD9;
  localparam logic [7:0] CMD_COM_PINS  = 8'hDA;
  localparam logic [7:0] CMD_VCOMH     = 8'hDB;
  localparam logic [7:0] CMD_CHG_PUMP  = 8'h8D;

  // Panel-setup commands whose single argument is swallowed without effect.
  function automatic logic has_ignored_arg(input logic [7:0] op);
    logic hit;
    hit = 1'b0;
    case (op)
      CMD_CONTRAST, CMD_MUX_RATIO, CMD_OFFSET, CMD_CLK_DIV,
      CMD_PRECHARGE, CMD_COM_PINS, CMD_VCOMH, CMD_CHG_PUMP: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ssd1309_spi_receiver_if.sv
// Pixel write port: request held with address/data until the consumer acknowledges.
interface ssd1309_spi_receiver_if;
  logic       we;
  logic [7:0] w_xpos;
  logic [7:0] w_ypos;
  logic [7:0] din;
  logic       w_data_valid;

  modport master (output we, output w_xpos, output w_ypos, output din, input w_data_valid);
  modport slave  (input we, input w_xpos, input w_ypos, input din, output w_data_valid);
endinterface

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte deserializer: 2-FF synchronizers, sclk rise detect, MSB-first shift.
// byte_valid pulses one clk after the 8th edge, with dc captured alongside bit 0.
module spi_byte_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       sdin,
  input  logic       dc,
  input  logic       cs,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       is_data
);

  // Bit order in the synchronizer vectors: {sclk, sdin, dc, cs}
  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;
  logic       sclk_d_reg;
  logic [6:0] shift_reg;
  logic [2:0] cnt_reg;
  logic       byte_valid_reg;
  logic [7:0] rx_byte_reg;
  logic       is_data_reg;

  logic sclk_s, sdin_s, dc_s, cs_s, sclk_rise;

  assign sclk_s    = sync2_reg[3];
  assign sdin_s    = sync2_reg[2];
  assign dc_s      = sync2_reg[1];
  assign cs_s      = sync2_reg[0];
  assign sclk_rise = sclk_s & ~sclk_d_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg      <= 4'b0001;
      sync2_reg      <= 4'b0001;
      sclk_d_reg     <= 1'b0;
      shift_reg      <= '0;
      cnt_reg        <= '0;
      byte_valid_reg <= 1'b0;
      rx_byte_reg    <= '0;
      is_data_reg    <= 1'b0;
    end else begin
      sync1_reg      <= {sclk, sdin, dc, cs};
      sync2_reg      <= sync1_reg;
      sclk_d_reg     <= sclk_s;
      byte_valid_reg <= 1'b0;
      if (cs_s) begin
        cnt_reg   <= '0;
        shift_reg <= '0;
      end else if (sclk_rise) begin
        shift_reg <= {shift_reg[5:0], sdin_s};
        cnt_reg   <= cnt_reg + 3'd1;
        if (cnt_reg == 3'd7) begin
          byte_valid_reg <= 1'b1;
          rx_byte_reg    <= {shift_reg, sdin_s};
          is_data_reg    <= dc_s;
        end
      end
    end
  end

  assign byte_valid = byte_valid_reg;
  assign rx_byte    = rx_byte_reg;
  assign is_data    = is_data_reg;

endmodule

// File: rtl/ssd1309_spi_receiver.sv
// SSD1309-style SPI front end: parses commands, tracks the GDDRAM address window and issues pixel writes.
// Optional page addressing mode (mode=2) is enabled with macro SSD_RX_PAGE_MODE_EN.
module ssd1309_spi_receiver
  import ssd1309_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int PAGES = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sclk,
  input  logic                           sdin,
  input  logic                           dc,
  input  logic                           cs,
  ssd1309_spi_receiver_if.master         wr,
  output logic                           busy,
  output logic                           overrun
);

  localparam logic [6:0] COL_MAX  = 7'(WIDTH - 1);
  localparam logic [2:0] PAGE_MAX = 3'(PAGES - 1);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       is_data;

  spi_byte_rx u_rx (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .sdin      (sdin),
    .dc        (dc),
    .cs        (cs),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .is_data   (is_data)
  );

  parser_state_t state_reg, state_next;
  logic [7:0] cmd_reg, cmd_next;
  logic [1:0] mode_reg, mode_next;
  logic [6:0] col_start_reg, col_start_next, col_end_reg, col_end_next, col_reg, col_next;
  logic [2:0] page_start_reg, page_start_next, page_end_reg, page_end_next, page_reg, page_next;
  logic       we_reg, we_next, overrun_reg, overrun_next;
  logic [7:0] xpos_reg, xpos_next, ypos_reg, ypos_next, din_reg, din_next;

  logic       col_at_end, page_at_end;
  logic [6:0] col_step;
  logic [2:0] page_step;

  assign col_at_end  = (col_reg == col_end_reg);
  assign page_at_end = (page_reg == page_end_reg);
  assign col_step    = col_at_end ? col_start_reg : col_reg + 7'd1;
  assign page_step   = page_at_end ? page_start_reg : page_reg + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= P_CMD;
      cmd_reg        <= '0;
      mode_reg       <= ADDR_HORIZ;
      col_start_reg  <= '0;
      col_end_reg    <= COL_MAX;
      page_start_reg <= '0;
      page_end_reg   <= PAGE_MAX;
      col_reg        <= '0;
      page_reg       <= '0;
      we_reg         <= 1'b0;
      xpos_reg       <= '0;
      ypos_reg       <= '0;
      din_reg        <= '0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cmd_reg        <= cmd_next;
      mode_reg       <= mode_next;
      col_start_reg  <= col_start_next;
      col_end_reg    <= col_end_next;
      page_start_reg <= page_start_next;
      page_end_reg   <= page_end_next;
      col_reg        <= col_next;
      page_reg       <= page_next;
      we_reg         <= we_next;
      xpos_reg       <= xpos_next;
      ypos_reg       <= ypos_next;
      din_reg        <= din_next;
      overrun_reg    <= overrun_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cmd_next        = cmd_reg;
    mode_next       = mode_reg;
    col_start_next  = col_start_reg;
    col_end_next    = col_end_reg;
    page_start_next = page_start_reg;
    page_end_next   = page_end_reg;
    col_next        = col_reg;
    page_next       = page_reg;
    we_next         = we_reg;
    xpos_next       = xpos_reg;
    ypos_next       = ypos_reg;
    din_next        = din_reg;
    overrun_next    = overrun_reg;

    if (we_reg && wr.w_data_valid) we_next = 1'b0;

    if (byte_valid && is_data) begin
      // A byte landing while the previous write is still outstanding is lost, including in the ack cycle.
      if (we_reg) begin
        overrun_next = 1'b1;
      end else begin
        we_next   = 1'b1;
        xpos_next = {1'b0, col_reg};
        ypos_next = {2'b00, page_reg, 3'b000};
        din_next  = rx_byte;
        case (mode_reg)
          ADDR_VERT: begin
            page_next = page_step;
            if (page_at_end) col_next = col_step;
          end
`ifdef SSD_RX_PAGE_MODE_EN
          ADDR_PAGE: col_next = (col_reg == COL_MAX) ? 7'd0 : col_reg + 7'd1;
`endif
          default: begin
            col_next = col_step;
            if (col_at_end) page_next = page_step;
          end
        endcase
      end
    end else if (byte_valid) begin
      case (state_reg)
        P_CMD: begin
          cmd_next = rx_byte;
          case (rx_byte)
            CMD_MEM_MODE, CMD_COL_ADDR, CMD_PAGE_ADDR: state_next = P_ARG1;
            default: begin
              if (has_ignored_arg(rx_byte)) state_next = P_ARG1;
`ifdef SSD_RX_PAGE_MODE_EN
              else if (mode_reg == ADDR_PAGE) begin
                if (rx_byte[7:3] == 5'b10110) page_next = rx_byte[2:0];
                else if (rx_byte[7:4] == 4'h0) col_next[3:0] = rx_byte[3:0];
                else if (rx_byte[7:3] == 5'b00010) col_next[6:4] = rx_byte[2:0];
              end
`endif
            end
          endcase
        end
        P_ARG1: begin
          state_next = P_CMD;
          case (cmd_reg)
            CMD_MEM_MODE: mode_next = rx_byte[1:0];
            CMD_COL_ADDR: begin
              col_start_next = rx_byte[6:0];
              col_next       = rx_byte[6:0];
              state_next     = P_ARG2;
            end
            CMD_PAGE_ADDR: begin
              page_start_next = rx_byte[2:0];
              page_next       = rx_byte[2:0];
              state_next      = P_ARG2;
            end
            default: state_next = P_CMD;
          endcase
        end
        P_ARG2: begin
          state_next = P_CMD;
          if (cmd_reg == CMD_COL_ADDR) col_end_next = rx_byte[6:0];
          else if (cmd_reg == CMD_PAGE_ADDR) page_end_next = rx_byte[2:0];
        end
        default: state_next = P_CMD;
      endcase
    end
  end

  assign wr.we     = we_reg;
  assign wr.w_xpos = xpos_reg;
  assign wr.w_ypos = ypos_reg;
  assign wr.din    = din_reg;
  assign busy      = we_reg;
  assign overrun   = overrun_reg;

endmodule

// File: doc/ssd1309_spi_receiver.md
SSD1309_SPI_RECEIVER -- requirements
Module: ssd1309_spi_receiver

Interface
REQ-001 SHALL provide parameter WIDTH, default 128, panel columns.
REQ-002 SHALL provide parameter PAGES, default 8, panel pages of 8 rows each.
REQ-003 SHALL have one clock and a synchronous, active-high reset. Ports: clk, input, 1, system clock; rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have the following SPI inputs, all asynchronous to clk:
- sclk, input, 1, SPI clock.
- sdin, input, 1, serial data, MSB first.
- dc, input, 1, command (0) or data (1).
- cs, input, 1, chip select, active low.
REQ-005 SHALL have the following write-port signals:
- we, output, 1, write request.
- w_xpos, output, 8, column.
- w_ypos, output, 8, page times 8.
- din, output, 8, pixel byte.
- w_data_valid, input, 1, write acknowledge.
REQ-006 SHALL have the following status outputs:
- busy, output, 1, write pending.
- overrun, output, 1, sticky byte-dropped flag.

Function
REQ-007 SHALL pass sclk, sdin, dc and cs through 2-FF synchronizers. Supported SCLK is at most clk/4.
REQ-008 SHALL shift in sdin on each synchronized sclk rising edge while cs is low, MSB first.
REQ-009 SHALL sample dc together with bit 0, i.e. on the 8th edge. The completed byte SHALL be tagged internally one cycle after that edge.
REQ-010 SHALL clear the bit counter when cs is high. A partial byte SHALL be discarded and no command or data effect SHALL occur.
REQ-011 SHALL run the parser FSM with states P_CMD, P_ARG1 and P_ARG2. A data byte SHALL be accepted in any state and SHALL not alter the parser state.
REQ-012 SHALL decode the following command bytes in P_CMD:
- 0x20: next byte sets mode[1:0].
- 0x21: next two bytes set col_start, then col_end (7 bits each); col is set to col_start.
- 0x22: next two bytes set page_start, then page_end (3 bits each); page is set to page_start.
- 0x81, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB, 0x8D: one argument byte, consumed and ignored.
- Any other value: ignored, parser stays in P_CMD.
REQ-013 SHALL, on each data byte, present the write request: we=1, w_xpos=col, w_ypos=page*8, din=byte.
REQ-014 SHALL hold the write request until w_data_valid=1. we SHALL drop on the cycle after the acknowledge. busy SHALL equal the pending state.
REQ-015 SHALL advance the address at request capture, by mode:
- Horizontal (0): col++. At col_end, col wraps to col_start and page++. At page_end, page wraps to page_start.
- Vertical (1): page++. At page_end, page wraps to page_start and col++ with column wrap.
REQ-016 SHALL, when a data byte completes while a write is pending, drop that byte, set overrun=1, and not advance the address.
REQ-017 SHALL apply command address updates only to subsequent data bytes. A pending write SHALL retain the address it was captured with.
REQ-018 SHALL treat mode=3 as horizontal.

Reset
REQ-019 SHALL on rst:
- Outputs: we=0, w_xpos=0, w_ypos=0, din=0, busy=0, overrun=0.
- Parser state: P_CMD.
- Address registers: mode=0, col_start=0, col_end=WIDTH-1, page_start=0, page_end=PAGES-1, col=0, page=0.
- Shift register and bit counter cleared.
REQ-020 SHALL, on rst asserted mid-byte or mid-write, abandon the transfer. No write SHALL be issued after reset for pre-reset bits.

Configuration
REQ-021 SHALL, when macro SSD_RX_PAGE_MODE_EN is defined, support page mode (mode=2) as follows:
- 0xB0-0xB7 sets page=byte[2:0].
- 0x00-0x0F sets col[3:0]; 0x10-0x17 sets col[6:4].
- Data bytes increment col, wrapping WIDTH-1 to 0, with page unchanged.
REQ-022 SHALL, when SSD_RX_PAGE_MODE_EN is undefined, treat mode=2 as horizontal and ignore 0xB0-0xB7, 0x00-0x0F and 0x10-0x17 as unknown commands.

Structure
REQ-023 SHALL place the following in a shared package ssd1309_pkg:
- Command opcode constants.
- Addressing-mode constants (ADDR_HORIZ, ADDR_VERT, ADDR_PAGE).
- Parser state encoding.
REQ-024 SHALL implement the SPI deserializer (synchronizers, edge detect, shift, byte/dc strobe) as sub-module spi_byte_rx.

Verification
REQ-025 SHALL cover data 0xA5 with dc=1 after reset -> one write at w_xpos=0, w_ypos=0, din=0xA5; next write at w_xpos=1.
REQ-026 SHALL cover commands 0x21,0x10,0x11 then 0x22,0x02,0x03 then 5 data bytes -> writes at (16,16), (17,16), (16,24), (17,24), (16,16).
REQ-027 SHALL cover 0x20,0x01 then 9 data bytes with default window -> writes at pages 0..7 of column 0, then page 0 of column 1.
REQ-028 SHALL cover holding w_data_valid=0 while two data bytes arrive -> first request held stable, second byte dropped, overrun=1; first write completes on acknowledge.
REQ-029 SHALL cover cs raised after 5 bits, then a full byte 0x3C -> only 0x3C processed, with no effect from the partial byte.
REQ-030 SHALL cover, with SSD_RX_PAGE_MODE_EN defined, 0x20,0x02,0xB3,0x05,0x12 then data 0xFF -> write at w_xpos=37, w_ypos=24; the same sequence without the macro -> write at (0,0).
